id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 5-stage F-D-E-M-WB pipeline.
- Sits directly downstream of the register file. It drives the file's read addresses from the fetched instruction and consumes the read data.
- Applies write-back-to-decode bypass and x0 masking, then decodes control.
- Detects load-use hazards (stall plus bubble), honours branch flush, and registers everything for the EX stage.

Parameters:
- XLEN, 32, datapath and PC width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- instr_d  in  XLEN  instruction from IF/ID register
- pc_d  in  XLEN  PC of instr_d
- valid_d  in  1  instr_d is a real instruction
- a1  out  RA_W  register file read address 1 = instr_d[19:15] (combinational)
- a2  out  RA_W  register file read address 2 = instr_d[24:20] (combinational)
- rd1  in  XLEN  register file read data 1
- rd2  in  XLEN  register file read data 2
- wb_rfw  in  1  WB stage write enable (same signal that drives the file's write enable)
- wb_a3  in  RA_W  WB destination
- wb_wd  in  XLEN  WB write data
- flush_e  in  1  squash the instruction entering EX (taken branch)
- stall_d  out  1  hold PC and IF/ID (combinational)
- valid_e  out  1  EX slot holds a real instruction
- pc_e  out  XLEN  registered PC
- rs1_val_e  out  XLEN  registered operand 1
- rs2_val_e  out  XLEN  registered operand 2
- imm_e  out  XLEN  registered sign-extended immediate
- rs1_e  out  RA_W  registered source address 1, for EX forwarding
- rs2_e  out  RA_W  registered source address 2, for EX forwarding
- rd_e  out  RA_W  registered destination
- alu_ctrl_e  out  4  registered ALU operation
- alu_src_e  out  1  1 = ALU B input takes imm_e
- mem_read_e  out  1  registered load flag
- mem_write_e  out  1  registered store flag
- reg_write_e  out  1  registered register-write flag
- illegal_e  out  1  unknown opcode reached EX

Behaviour:
- Decode by opcode = instr_d[6:0]:
  - 0110011 (R): reg_write=1, alu_src=0, alu_ctrl={instr[30], funct3}, uses rs1 and rs2.
  - 0010011 (I-ALU): reg_write=1, alu_src=1, imm=sext(instr[31:20]), alu_ctrl={funct3==101 ? instr[30] : 0, funct3}, uses rs1.
  - 0000011 (load): mem_read=1, reg_write=1, alu_src=1, alu_ctrl=0000, imm as I-type, uses rs1.
  - 0100011 (store): mem_write=1, alu_src=1, alu_ctrl=0000, imm=sext({instr[31:25], instr[11:7]}), uses rs1 and rs2.
  - Any other opcode: all control 0, illegal=1, uses no sources.
- rd field = instr[11:7]. reg_write is forced 0 when rd = 0.
- Operand select for each source, in priority order:
  - address 0 → 0;
  - else wb_rfw and wb_a3 equals the address → wb_wd. This bypass is required because the file writes on the clock edge and reads combinationally;
  - else rd1/rd2.
- Hazard = valid_d & valid_e & mem_read_e & rd_e≠0 & ((uses rs1 & rd_e==rs1) | (uses rs2 & rd_e==rs2)).
- stall_d = hazard & ~flush_e.
- Register update at posedge clk, in priority order:
  1. rst: all outputs 0, asynchronously.
  2. flush_e: bubble.
  3. hazard: bubble.
  4. Otherwise: load decoded values, with valid_e=valid_d.
- A bubble sets valid_e, reg_write_e, mem_read_e, mem_write_e and illegal_e to 0. Datapath fields may hold any value but are driven to 0.
- When valid_d=0, all control is registered as 0 and no hazard is raised.
- Latency is 1 cycle from D to E. A load-use sequence costs exactly 1 stall cycle: after the bubble, mem_read_e=0, so the hazard clears.
- Reset mid-stall: stall_d drops immediately because valid_e=0.

Test Plan:
- Reset → every output 0 and stall_d=0. After release, an R-type add (funct7=0000000, rs1=3, rs2=4, rd=5) with file contents r3=3, r4=4 → next cycle rs1_val_e=3, rs2_val_e=4, rd_e=5, alu_ctrl_e=0000, reg_write_e=1.
- Bypass: wb_rfw=1, wb_a3=3, wb_wd=0xDEAD_BEEF in the same cycle as the add above → rs1_val_e=0xDEADBEEF. With wb_a3=0 instead → rs1_val_e=3.
- x0 handling: instruction with rs1=0, and rd1 driven 0xFFFF_FFFF → rs1_val_e=0. An R-type with rd=0 → reg_write_e=0.
- Load-use sequence:
  - issue lw x6,8(x2) → mem_read_e=1, imm_e=8;
  - next, add x7,x6,x1 → stall_d=1 for one cycle and a bubble enters EX (valid_e=0);
  - following cycle → add in EX with rs1_e=6, stall_d=0.
- Flush concurrent with a load-use hazard → stall_d=0 and a bubble is registered. Store sw x2,-4(x1) → imm_e=0xFFFF_FFFC, mem_write_e=1, reg_write_e=0.
- Illegal opcode 0x7F → illegal_e=1 and all control 0. srai (funct3=101, instr[30]=1) → alu_ctrl_e=1101, alu_src_e=1.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
//   Bundles every non-clock/reset signal of the decode / ID-EX register
//   block. The stage itself connects through the master modport, the
//   surrounding pipeline (IF/ID register, register file, WB and EX stages)
//   through the slave modport.
//
//   Ports (viewed from the stage):
//     in : instr_d, pc_d, valid_d, rd1, rd2, wb_rfw, wb_a3, wb_wd, flush_e
//     out: a1, a2, stall_d, valid_e, pc_e, rs1_val_e, rs2_val_e, imm_e,
//          rs1_e, rs2_e, rd_e, alu_ctrl_e, alu_src_e, mem_read_e,
//          mem_write_e, reg_write_e, illegal_e
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic            valid_d;
  logic [RA_W-1:0] a1;
  logic [RA_W-1:0] a2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            wb_rfw;
  logic [RA_W-1:0] wb_a3;
  logic [XLEN-1:0] wb_wd;
  logic            flush_e;
  logic            stall_d;
  logic            valid_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] rs1_val_e;
  logic [XLEN-1:0] rs2_val_e;
  logic [XLEN-1:0] imm_e;
  logic [RA_W-1:0] rs1_e;
  logic [RA_W-1:0] rs2_e;
  logic [RA_W-1:0] rd_e;
  logic [3:0]      alu_ctrl_e;
  logic            alu_src_e;
  logic            mem_read_e;
  logic            mem_write_e;
  logic            reg_write_e;
  logic            illegal_e;

  modport master (
    input  instr_d, pc_d, valid_d, rd1, rd2, wb_rfw, wb_a3, wb_wd, flush_e,
    output a1, a2, stall_d, valid_e, pc_e, rs1_val_e, rs2_val_e, imm_e,
           rs1_e, rs2_e, rd_e, alu_ctrl_e, alu_src_e, mem_read_e,
           mem_write_e, reg_write_e, illegal_e
  );

  modport slave (
    output instr_d, pc_d, valid_d, rd1, rd2, wb_rfw, wb_a3, wb_wd, flush_e,
    input  a1, a2, stall_d, valid_e, pc_e, rs1_val_e, rs2_val_e, imm_e,
           rs1_e, rs2_e, rd_e, alu_ctrl_e, alu_src_e, mem_read_e,
           mem_write_e, reg_write_e, illegal_e
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Decode stage plus ID/EX pipeline register. Drives the register file read
//   addresses straight from the fetched instruction, merges the returned data
//   with the write-back value (x0 reads as zero), decodes control for R, I-ALU,
//   load and store opcodes, detects load-use hazards and registers the result
//   for EX.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset, clears every registered output
//     bus  - id_ex_stage_if.master, decode inputs, register file read port,
//            write-back bypass inputs, flush, stall and all EX-side outputs
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic           clk,
  input logic           rst,
  id_ex_stage_if.master bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [RA_W-1:0] rs1;
  logic [RA_W-1:0] rs2;
  logic [RA_W-1:0] rd;

  logic            dec_rw;
  logic            dec_mr;
  logic            dec_mw;
  logic            dec_src;
  logic            dec_ill;
  logic [3:0]      dec_alu;
  logic [XLEN-1:0] dec_imm;
  logic            uses_rs1;
  logic            uses_rs2;

  logic [XLEN-1:0] opnd1;
  logic [XLEN-1:0] opnd2;
  logic            hazard;

  assign opcode = bus.instr_d[6:0];
  assign funct3 = bus.instr_d[14:12];
  assign rs1    = bus.instr_d[15 +: RA_W];
  assign rs2    = bus.instr_d[20 +: RA_W];
  assign rd     = bus.instr_d[7 +: RA_W];

  assign bus.a1 = rs1;
  assign bus.a2 = rs2;

  // The file writes on the clock edge but is read combinationally, so a value
  // being written back this cycle has to be taken from the WB bus instead.
  function automatic logic [XLEN-1:0] select_operand(
    input logic [RA_W-1:0] addr,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_rfw,
    input logic [RA_W-1:0] wb_a3,
    input logic [XLEN-1:0] wb_wd
  );
    if (addr == '0)
      return '0;
    else if (wb_rfw && (wb_a3 == addr))
      return wb_wd;
    else
      return rf_data;
  endfunction

  assign opnd1 = select_operand(rs1, bus.rd1, bus.wb_rfw, bus.wb_a3, bus.wb_wd);
  assign opnd2 = select_operand(rs2, bus.rd2, bus.wb_rfw, bus.wb_a3, bus.wb_wd);

  always_comb begin
    dec_rw   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_src  = 1'b0;
    dec_ill  = 1'b0;
    dec_alu  = 4'b0000;
    dec_imm  = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;

    case (opcode)
      OP_R: begin
        dec_rw   = 1'b1;
        dec_alu  = {bus.instr_d[30], funct3};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_I: begin
        dec_rw   = 1'b1;
        dec_src  = 1'b1;
        dec_imm  = {{(XLEN-12){bus.instr_d[31]}}, bus.instr_d[31:20]};
        // Only the shift-right group uses instr[30] (logical vs arithmetic);
        // for the other immediates that bit is part of the constant.
        dec_alu  = {(funct3 == 3'b101) & bus.instr_d[30], funct3};
        uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        dec_mr   = 1'b1;
        dec_rw   = 1'b1;
        dec_src  = 1'b1;
        dec_imm  = {{(XLEN-12){bus.instr_d[31]}}, bus.instr_d[31:20]};
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        dec_mw   = 1'b1;
        dec_src  = 1'b1;
        dec_imm  = {{(XLEN-12){bus.instr_d[31]}}, bus.instr_d[31:25], bus.instr_d[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase

    if (rd == '0)
      dec_rw = 1'b0;

    // An empty decode slot carries no control at all into EX.
    if (!bus.valid_d) begin
      dec_rw  = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_src = 1'b0;
      dec_ill = 1'b0;
      dec_alu = 4'b0000;
    end
  end

  // A load in EX cannot forward its data in time for a dependent instruction
  // in decode; hold decode one cycle and send a bubble instead.
  assign hazard = bus.valid_d && bus.valid_e && bus.mem_read_e && (bus.rd_e != '0) &&
                  ((uses_rs1 && (bus.rd_e == rs1)) || (uses_rs2 && (bus.rd_e == rs2)));

  // A flush discards the decode instruction anyway, so there is nothing to hold.
  assign bus.stall_d = hazard & ~bus.flush_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.flush_e || hazard) begin
      bus.valid_e     <= 1'b0;
      bus.pc_e        <= '0;
      bus.rs1_val_e   <= '0;
      bus.rs2_val_e   <= '0;
      bus.imm_e       <= '0;
      bus.rs1_e       <= '0;
      bus.rs2_e       <= '0;
      bus.rd_e        <= '0;
      bus.alu_ctrl_e  <= 4'b0000;
      bus.alu_src_e   <= 1'b0;
      bus.mem_read_e  <= 1'b0;
      bus.mem_write_e <= 1'b0;
      bus.reg_write_e <= 1'b0;
      bus.illegal_e   <= 1'b0;
    end else begin
      bus.valid_e     <= bus.valid_d;
      bus.pc_e        <= bus.pc_d;
      bus.rs1_val_e   <= opnd1;
      bus.rs2_val_e   <= opnd2;
      bus.imm_e       <= dec_imm;
      // Unused source fields are zeroed so EX forwarding never matches on
      // immediate bits that merely look like a register address.
      bus.rs1_e       <= uses_rs1 ? rs1 : '0;
      bus.rs2_e       <= uses_rs2 ? rs2 : '0;
      bus.rd_e        <= rd;
      bus.alu_ctrl_e  <= dec_alu;
      bus.alu_src_e   <= dec_src;
      bus.mem_read_e  <= dec_mr;
      bus.mem_write_e <= dec_mw;
      bus.reg_write_e <= dec_rw;
      bus.illegal_e   <= dec_ill;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage: a table of directed vectors, a
//   reset-during-stall sequence, then randomized instructions compared
//   against an instruction-level reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_rfw;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic        flush;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        src;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        ill;
  } ex_t;

  typedef struct packed {
    in_t  in;
    logic stall;
    ex_t  ex;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] encR(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                       logic [2:0] f3, logic [4:0] rdd);
    return {f7, r2, r1, f3, rdd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encI(logic [11:0] imm, logic [4:0] r1, logic [2:0] f3,
                                       logic [4:0] rdd, logic [6:0] op);
    return {imm, r1, f3, rdd, op};
  endfunction

  function automatic logic [31:0] encS(logic [11:0] imm, logic [4:0] r2, logic [4:0] r1,
                                       logic [2:0] f3);
    return {imm[11:5], r2, r1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic in_t mkIn(logic [31:0] instr, logic [31:0] pc, logic valid,
                               logic [31:0] rd1, logic [31:0] rd2, logic wb_rfw,
                               logic [4:0] wb_a3, logic [31:0] wb_wd, logic flush);
    in_t r;
    r.instr = instr; r.pc = pc; r.valid = valid; r.rd1 = rd1; r.rd2 = rd2;
    r.wb_rfw = wb_rfw; r.wb_a3 = wb_a3; r.wb_wd = wb_wd; r.flush = flush;
    return r;
  endfunction

  function automatic ex_t mkEx(logic valid, logic [31:0] pc, logic [31:0] v1, logic [31:0] v2,
                               logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                               logic [4:0] rd, logic [3:0] alu, logic src, logic mr,
                               logic mw, logic rw, logic ill);
    ex_t e;
    e.valid = valid; e.pc = pc; e.v1 = v1; e.v2 = v2; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.alu = alu;
    e.src = src; e.mr = mr; e.mw = mw; e.rw = rw; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t mkVec(in_t in, logic stall, ex_t ex);
    vec_t v;
    v.in = in; v.stall = stall; v.ex = ex;
    return v;
  endfunction

  // Reference model: what an instruction means, one instruction at a time.
  function automatic logic [31:0] modelOperand(logic [4:0] addr, logic [31:0] fileData, in_t in);
    if (addr == 5'd0) return 32'd0;
    if (in.wb_rfw && in.wb_a3 == addr) return in.wb_wd;
    return fileData;
  endfunction

  function automatic ex_t modelDecode(in_t in);
    ex_t         e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [11:0] simm;
    logic        isR, isI, isL, isS;
    op = in.instr[6:0];
    f3 = in.instr[14:12];
    s1 = in.instr[19:15];
    s2 = in.instr[24:20];
    isR = (op == 7'h33);
    isI = (op == 7'h13);
    isL = (op == 7'h03);
    isS = (op == 7'h23);
    e = '0;
    e.valid = in.valid;
    e.pc = in.pc;
    e.v1 = modelOperand(s1, in.rd1, in);
    e.v2 = modelOperand(s2, in.rd2, in);
    e.rs1 = (isR || isI || isL || isS) ? s1 : 5'd0;
    e.rs2 = (isR || isS) ? s2 : 5'd0;
    e.rd = in.instr[11:7];
    if (isI || isL) e.imm = int'($signed(in.instr[31:20]));
    if (isS) begin
      simm = {in.instr[31:25], in.instr[11:7]};
      e.imm = int'($signed(simm));
    end
    if (in.valid) begin
      if (isR) e.alu = {in.instr[30], f3};
      else if (isI) e.alu = (f3 == 3'd5) ? {in.instr[30], f3} : {1'b0, f3};
      e.src = isI || isL || isS;
      e.mr = isL;
      e.mw = isS;
      e.rw = (isR || isI || isL) && (e.rd != 5'd0);
      e.ill = !(isR || isI || isL || isS);
    end
    return e;
  endfunction

  function automatic logic modelHazard(in_t in, ex_t inEx);
    logic [6:0] op;
    logic       needs1, needs2;
    op = in.instr[6:0];
    needs1 = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23);
    needs2 = (op == 7'h33) || (op == 7'h23);
    return in.valid && inEx.valid && inEx.mr && (inEx.rd != 5'd0) &&
           ((needs1 && inEx.rd == in.instr[19:15]) || (needs2 && inEx.rd == in.instr[24:20]));
  endfunction

  function automatic logic [31:0] randInstr();
    logic [4:0]  r1, r2, rdd;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  op;
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    rdd = 5'($urandom_range(0, 7));
    f3  = 3'($urandom);
    imm = 12'($urandom);
    case ($urandom_range(0, 5))
      0: return encR(($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r2, r1, f3, rdd);
      1: return encI(imm, r1, f3, rdd, 7'h13);
      2, 5: return encI(imm, r1, 3'd2, rdd, 7'h03);
      3: return encS(imm, r2, r1, 3'd2);
      default: begin
        op = 7'($urandom);
        if (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23) op = 7'h7F;
        return {7'($urandom), r2, r1, f3, rdd, op};
      end
    endcase
  endfunction

  task automatic check32(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic checkOutput(string tag, ex_t e);
    check32({tag, ".valid_e"},     32'(bus.valid_e),     32'(e.valid));
    check32({tag, ".pc_e"},        bus.pc_e,             e.pc);
    check32({tag, ".rs1_val_e"},   bus.rs1_val_e,        e.v1);
    check32({tag, ".rs2_val_e"},   bus.rs2_val_e,        e.v2);
    check32({tag, ".imm_e"},       bus.imm_e,            e.imm);
    check32({tag, ".rs1_e"},       32'(bus.rs1_e),       32'(e.rs1));
    check32({tag, ".rs2_e"},       32'(bus.rs2_e),       32'(e.rs2));
    check32({tag, ".rd_e"},        32'(bus.rd_e),        32'(e.rd));
    check32({tag, ".alu_ctrl_e"},  32'(bus.alu_ctrl_e),  32'(e.alu));
    check32({tag, ".alu_src_e"},   32'(bus.alu_src_e),   32'(e.src));
    check32({tag, ".mem_read_e"},  32'(bus.mem_read_e),  32'(e.mr));
    check32({tag, ".mem_write_e"}, 32'(bus.mem_write_e), 32'(e.mw));
    check32({tag, ".reg_write_e"}, 32'(bus.reg_write_e), 32'(e.rw));
    check32({tag, ".illegal_e"},   32'(bus.illegal_e),   32'(e.ill));
  endtask

  task automatic driveInputs(in_t in);
    bus.instr_d = in.instr;
    bus.pc_d    = in.pc;
    bus.valid_d = in.valid;
    bus.rd1     = in.rd1;
    bus.rd2     = in.rd2;
    bus.wb_rfw  = in.wb_rfw;
    bus.wb_a3   = in.wb_a3;
    bus.wb_wd   = in.wb_wd;
    bus.flush_e = in.flush;
  endtask

  // Drive on the falling edge, check the combinational outputs just after,
  // then check the registered outputs just after the next rising edge.
  task automatic applyStimulus(in_t in, logic expStall, ex_t expEx, string tag);
    @(negedge clk);
    driveInputs(in);
    #1;
    check32({tag, ".a1"},      32'(bus.a1),      32'(in.instr[19:15]));
    check32({tag, ".a2"},      32'(bus.a2),      32'(in.instr[24:20]));
    check32({tag, ".stall_d"}, 32'(bus.stall_d), 32'(expStall));
    @(posedge clk);
    #1;
    checkOutput(tag, expEx);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    driveInputs('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t        vecs[24];
    logic [31:0] addI, lwI, add76, swI, sw6, srai, andi, subI, addi;
    in_t         cur;
    ex_t         model;
    ex_t         nxt;
    logic        hz;
    logic        expStall;
    logic        held;

    addI  = encR(7'h00, 5'd4, 5'd3, 3'd0, 5'd5);
    lwI   = encI(12'd8, 5'd2, 3'd2, 5'd6, 7'h03);
    add76 = encR(7'h00, 5'd1, 5'd6, 3'd0, 5'd7);
    swI   = encS(12'hFFC, 5'd2, 5'd1, 3'd2);
    sw6   = encS(12'h000, 5'd6, 5'd1, 3'd2);
    srai  = encI(12'h403, 5'd8, 3'd5, 5'd9, 7'h13);
    andi  = encI(12'hC00, 5'd5, 3'd7, 5'd10, 7'h13);
    subI  = encR(7'h20, 5'd4, 5'd3, 3'd0, 5'd11);
    addi  = encI(12'h006, 5'd1, 3'd0, 5'd9, 7'h13);

    vecs[0]  = mkVec(mkIn(addI, 32'h100, 1, 3, 4, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h100, 3, 4, 0, 3, 4, 5, 4'h0, 0, 0, 0, 1, 0));
    vecs[1]  = mkVec(mkIn(addI, 32'h104, 1, 3, 4, 1, 3, 32'hDEADBEEF, 0), 0,
                     mkEx(1, 32'h104, 32'hDEADBEEF, 4, 0, 3, 4, 5, 4'h0, 0, 0, 0, 1, 0));
    vecs[2]  = mkVec(mkIn(addI, 32'h108, 1, 3, 4, 1, 0, 32'hDEADBEEF, 0), 0,
                     mkEx(1, 32'h108, 3, 4, 0, 3, 4, 5, 4'h0, 0, 0, 0, 1, 0));
    vecs[3]  = mkVec(mkIn(encR(7'h00, 5'd4, 5'd0, 3'd0, 5'd5), 32'h10C, 1, 32'hFFFFFFFF, 4, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h10C, 0, 4, 0, 0, 4, 5, 4'h0, 0, 0, 0, 1, 0));
    vecs[4]  = mkVec(mkIn(encR(7'h00, 5'd4, 5'd3, 3'd0, 5'd0), 32'h110, 1, 3, 4, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h110, 3, 4, 0, 3, 4, 0, 4'h0, 0, 0, 0, 0, 0));
    vecs[5]  = mkVec(mkIn(lwI, 32'h114, 1, 2, 8, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h114, 2, 8, 8, 2, 0, 6, 4'h0, 1, 1, 0, 1, 0));
    vecs[6]  = mkVec(mkIn(add76, 32'h118, 1, 6, 1, 0, 0, 0, 0), 1, '0);
    vecs[7]  = mkVec(mkIn(add76, 32'h11C, 1, 6, 1, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h11C, 6, 1, 0, 6, 1, 7, 4'h0, 0, 0, 0, 1, 0));
    vecs[8]  = mkVec(mkIn(lwI, 32'h120, 1, 2, 8, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h120, 2, 8, 8, 2, 0, 6, 4'h0, 1, 1, 0, 1, 0));
    vecs[9]  = mkVec(mkIn(add76, 32'h124, 1, 6, 1, 0, 0, 0, 1), 0, '0);
    vecs[10] = mkVec(mkIn(swI, 32'h128, 1, 1, 2, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h128, 1, 2, 32'hFFFFFFFC, 1, 2, 28, 4'h0, 1, 0, 1, 0, 0));
    vecs[11] = mkVec(mkIn(32'h0000007F, 32'h12C, 1, 32'h1234, 32'h5678, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h12C, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1));
    vecs[12] = mkVec(mkIn(srai, 32'h130, 1, 8, 3, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h130, 8, 3, 32'h403, 8, 0, 9, 4'hD, 1, 0, 0, 1, 0));
    vecs[13] = mkVec(mkIn(lwI, 32'h134, 0, 2, 8, 0, 0, 0, 0), 0,
                     mkEx(0, 32'h134, 2, 8, 8, 2, 0, 6, 4'h0, 0, 0, 0, 0, 0));
    vecs[14] = mkVec(mkIn(add76, 32'h138, 1, 6, 1, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h138, 6, 1, 0, 6, 1, 7, 4'h0, 0, 0, 0, 1, 0));
    vecs[15] = mkVec(mkIn(andi, 32'h13C, 1, 5, 32'h55, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h13C, 5, 0, 32'hFFFFFC00, 5, 0, 10, 4'h7, 1, 0, 0, 1, 0));
    vecs[16] = mkVec(mkIn(subI, 32'h140, 1, 3, 4, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h140, 3, 4, 0, 3, 4, 11, 4'h8, 0, 0, 0, 1, 0));
    vecs[17] = mkVec(mkIn(addI, 32'h144, 1, 3, 4, 0, 4, 32'hAAAA0000, 0), 0,
                     mkEx(1, 32'h144, 3, 4, 0, 3, 4, 5, 4'h0, 0, 0, 0, 1, 0));
    vecs[18] = mkVec(mkIn(addI, 32'h148, 1, 3, 4, 1, 4, 32'h0000CAFE, 0), 0,
                     mkEx(1, 32'h148, 3, 32'h0000CAFE, 0, 3, 4, 5, 4'h0, 0, 0, 0, 1, 0));
    vecs[19] = mkVec(mkIn(lwI, 32'h14C, 1, 2, 8, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h14C, 2, 8, 8, 2, 0, 6, 4'h0, 1, 1, 0, 1, 0));
    vecs[20] = mkVec(mkIn(sw6, 32'h150, 1, 1, 6, 0, 0, 0, 0), 1, '0);
    vecs[21] = mkVec(mkIn(sw6, 32'h154, 1, 1, 6, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h154, 1, 6, 0, 1, 6, 0, 4'h0, 1, 0, 1, 0, 0));
    vecs[22] = mkVec(mkIn(lwI, 32'h158, 1, 2, 8, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h158, 2, 8, 8, 2, 0, 6, 4'h0, 1, 1, 0, 1, 0));
    vecs[23] = mkVec(mkIn(addi, 32'h15C, 1, 1, 6, 0, 0, 0, 0), 0,
                     mkEx(1, 32'h15C, 1, 6, 6, 1, 0, 9, 4'h0, 1, 0, 0, 1, 0));

    driveInputs('0);
    #2 rst = 1'b1;
    #4;
    checkOutput("reset", '0);
    check32("reset.stall_d", 32'(bus.stall_d), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 24; i++)
      applyStimulus(vecs[i].in, vecs[i].stall, vecs[i].ex, $sformatf("vec%0d", i));

    $display("[TB] reset during a load-use stall");
    applyStimulus(mkIn(lwI, 32'h200, 1, 2, 8, 0, 0, 0, 0), 0,
                  mkEx(1, 32'h200, 2, 8, 8, 2, 0, 6, 4'h0, 1, 1, 0, 1, 0), "ms_load");
    @(negedge clk);
    driveInputs(mkIn(add76, 32'h204, 1, 6, 1, 0, 0, 0, 0));
    #1;
    check32("ms.stall_before_reset", 32'(bus.stall_d), 32'd1);
    rst = 1'b1;
    #1;
    check32("ms.stall_in_reset", 32'(bus.stall_d), 32'd0);
    check32("ms.valid_in_reset", 32'(bus.valid_e), 32'd0);
    check32("ms.mem_read_in_reset", 32'(bus.mem_read_e), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ms_after", mkEx(1, 32'h204, 6, 1, 0, 6, 1, 7, 4'h0, 0, 0, 0, 1, 0));

    $display("[TB] randomized stream against reference model");
    doReset();
    model = '0;
    held  = 1'b0;
    cur   = '0;
    for (int c = 0; c < 400; c++) begin
      if (!held) begin
        cur.instr = randInstr();
        cur.pc    = $urandom;
        cur.valid = ($urandom_range(0, 9) != 0);
      end
      cur.rd1    = $urandom;
      cur.rd2    = $urandom;
      cur.wb_rfw = 1'($urandom_range(0, 1));
      cur.wb_a3  = 5'($urandom_range(0, 7));
      cur.wb_wd  = $urandom;
      cur.flush  = ($urandom_range(0, 7) == 0);
      hz       = modelHazard(cur, model);
      expStall = hz && !cur.flush;
      nxt      = (hz || cur.flush) ? ex_t'('0) : modelDecode(cur);
      applyStimulus(cur, expStall, nxt, $sformatf("rnd%0d", c));
      model = nxt;
      held  = expStall;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
